// File: rtl/mw_writeback_if.sv
// rtl/mw_writeback_if.sv - M->W pipeline bundle: memory-stage inputs and writeback-stage outputs
interface mw_writeback_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 64
);
  // Pipeline control from the hazard unit
  logic              StallW_i;
  logic              FlushW_i;
  // Memory-stage payload
  logic              ValidM_i;
  logic              RegWriteM_i;
  logic [1:0]        ResultSrcM_i;
  logic [2:0]        LoadTypeM_i;
  logic [DATA_W-1:0] ALUResultM_i;
  logic [DATA_W-1:0] ReadDataM_i;
  logic [DATA_W-1:0] PCPlus4M_i;
  logic [DATA_W-1:0] ImmExtM_i;
  logic [4:0]        RdM_i;
  // Writeback-stage results
  logic              ValidW_o;
  logic              RegWriteW_o;
  logic [4:0]        RdW_o;
  logic [DATA_W-1:0] ResultW_o;
  logic              LoadMisalignW_o;
  logic [CNT_W-1:0]  InstRetW_o;

  // Upstream pipeline / bench side
  modport master (
    output StallW_i, FlushW_i, ValidM_i, RegWriteM_i, ResultSrcM_i, LoadTypeM_i,
           ALUResultM_i, ReadDataM_i, PCPlus4M_i, ImmExtM_i, RdM_i,
    input  ValidW_o, RegWriteW_o, RdW_o, ResultW_o, LoadMisalignW_o, InstRetW_o
  );

  // Writeback stage side
  modport slave (
    input  StallW_i, FlushW_i, ValidM_i, RegWriteM_i, ResultSrcM_i, LoadTypeM_i,
           ALUResultM_i, ReadDataM_i, PCPlus4M_i, ImmExtM_i, RdM_i,
    output ValidW_o, RegWriteW_o, RdW_o, ResultW_o, LoadMisalignW_o, InstRetW_o
  );
endinterface

// File: rtl/mw_writeback.sv
// rtl/mw_writeback.sv - M->W pipeline register, load extraction, result mux and retire counter
module mw_writeback #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 64
) (
  input logic          clk,
  input logic          rst,
  mw_writeback_if.slave bus
);
  logic              valid_q;
  logic              reg_write_q;
  logic [1:0]        result_src_q;
  logic [2:0]        load_type_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] read_data_q;
  logic [DATA_W-1:0] pc_plus4_q;
  logic [DATA_W-1:0] imm_ext_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  inst_ret_q;

  logic [1:0]        off;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_data;
  logic              misaligned;
  logic              load_misalign;
  logic [DATA_W-1:0] result;

  // W pipeline register: reset > flush (bubble) > stall (hold) > capture
  always_ff @(posedge clk) begin
    if (rst || bus.FlushW_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
      load_type_q  <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      imm_ext_q    <= '0;
      rd_q         <= '0;
    end else if (!bus.StallW_i) begin
      valid_q      <= bus.ValidM_i;
      reg_write_q  <= bus.RegWriteM_i;
      result_src_q <= bus.ResultSrcM_i;
      load_type_q  <= bus.LoadTypeM_i;
      alu_result_q <= bus.ALUResultM_i;
      read_data_q  <= bus.ReadDataM_i;
      pc_plus4_q   <= bus.PCPlus4M_i;
      imm_ext_q    <= bus.ImmExtM_i;
      rd_q         <= bus.RdM_i;
    end
  end

  // Retire counter: an instruction counts on the edge it leaves W; a
  // flush still lets the current occupant retire, a stall keeps it in place
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_ret_q <= '0;
    end else if (valid_q && !bus.StallW_i && !load_misalign) begin
      inst_ret_q <= inst_ret_q + 1'b1;
    end
  end

  assign off       = alu_result_q[1:0];
  assign load_half = off[1] ? read_data_q[31:16] : read_data_q[15:0];

  // Byte lane select within the little-endian memory word
  always_comb begin
    load_byte = read_data_q[7:0];
    case (off)
      2'd0: load_byte = read_data_q[7:0];
      2'd1: load_byte = read_data_q[15:8];
      2'd2: load_byte = read_data_q[23:16];
      2'd3: load_byte = read_data_q[31:24];
      default: load_byte = read_data_q[7:0];
    endcase
  end

  // Load sign/zero extension and alignment check by funct3
  always_comb begin
    load_data  = read_data_q;
    misaligned = 1'b0;
    case (load_type_q)
      3'b000: load_data = {{24{load_byte[7]}}, load_byte};
      3'b100: load_data = {24'd0, load_byte};
      3'b001: begin
        load_data  = {{16{load_half[15]}}, load_half};
        misaligned = off[0];
      end
      3'b101: begin
        load_data  = {16'd0, load_half};
        misaligned = off[0];
      end
      3'b010: misaligned = (off != 2'd0);
      default: begin
        load_data  = read_data_q;
        misaligned = 1'b0;
      end
    endcase
  end

  assign load_misalign = valid_q && (result_src_q == 2'b01) && misaligned;

  // Writeback result select; driven regardless of slot validity
  always_comb begin
    result = alu_result_q;
    case (result_src_q)
      2'b00: result = alu_result_q;
      2'b01: result = load_data;
      2'b10: result = pc_plus4_q;
      2'b11: result = imm_ext_q;
      default: result = alu_result_q;
    endcase
  end

  assign bus.ValidW_o        = valid_q;
  assign bus.RdW_o           = rd_q;
  assign bus.ResultW_o       = result;
  assign bus.LoadMisalignW_o = load_misalign;
  assign bus.RegWriteW_o     = valid_q && reg_write_q && (rd_q != 5'd0) && !load_misalign;
  assign bus.InstRetW_o      = inst_ret_q;
endmodule

// File: tb/tb_mw_writeback.sv
// tb/tb_mw_writeback.sv - directed self-checking bench for mw_writeback
module tb_mw_writeback;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  mw_writeback_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mw_writeback #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4,
                       input logic [31:0] imm, input logic [4:0] rd);
    bus.ValidM_i     = v;
    bus.RegWriteM_i  = rw;
    bus.ResultSrcM_i = src;
    bus.LoadTypeM_i  = lt;
    bus.ALUResultM_i = alu;
    bus.ReadDataM_i  = rdata;
    bus.PCPlus4M_i   = pc4;
    bus.ImmExtM_i    = imm;
    bus.RdM_i        = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.ValidW_o), 64'd0);
    chk({tag, "_regwrite"}, 64'(bus.RegWriteW_o), 64'd0);
    chk({tag, "_rd"}, 64'(bus.RdW_o), 64'd0);
    chk({tag, "_result"}, 64'(bus.ResultW_o), 64'd0);
    chk({tag, "_misalign"}, 64'(bus.LoadMisalignW_o), 64'd0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.StallW_i = 1'b0;
    bus.FlushW_i = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    chk_idle("reset");
    chk("reset_cnt", 64'(bus.InstRetW_o), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk_idle("idle");
    chk("idle_cnt", 64'(bus.InstRetW_o), 64'd0);

    // LB at 0x1003 of 0x80FF1234 -> byte 0x80 sign-extended
    drive(1'b1, 1'b1, 2'b01, 3'b000, 32'h1003, 32'h80FF1234, 32'h0, 32'h0, 5'd5);
    tick();
    chk("lb_result", 64'(bus.ResultW_o), 64'hFFFFFF80);
    chk("lb_regwrite", 64'(bus.RegWriteW_o), 64'd1);
    chk("lb_rd", 64'(bus.RdW_o), 64'd5);
    chk("lb_cnt", 64'(bus.InstRetW_o), 64'd0);

    // LBU same address -> zero-extended
    drive(1'b1, 1'b1, 2'b01, 3'b100, 32'h1003, 32'h80FF1234, 32'h0, 32'h0, 5'd5);
    tick();
    chk("lbu_result", 64'(bus.ResultW_o), 64'h00000080);
    chk("lbu_cnt", 64'(bus.InstRetW_o), 64'd1);

    // LHU at 0x1002 -> upper half 0x80FF
    drive(1'b1, 1'b1, 2'b01, 3'b101, 32'h1002, 32'h80FF1234, 32'h0, 32'h0, 5'd5);
    tick();
    chk("lhu_result", 64'(bus.ResultW_o), 64'h000080FF);
    chk("lhu_regwrite", 64'(bus.RegWriteW_o), 64'd1);
    chk("lhu_cnt", 64'(bus.InstRetW_o), 64'd2);

    // LW at 0x1002 -> misaligned, no write
    drive(1'b1, 1'b1, 2'b01, 3'b010, 32'h1002, 32'h80FF1234, 32'h0, 32'h0, 5'd5);
    tick();
    chk("lw_misalign", 64'(bus.LoadMisalignW_o), 64'd1);
    chk("lw_regwrite", 64'(bus.RegWriteW_o), 64'd0);
    chk("lw_cnt", 64'(bus.InstRetW_o), 64'd3);

    // LH at 0x1001 -> misaligned; LW before it must not have retired
    drive(1'b1, 1'b1, 2'b01, 3'b001, 32'h1001, 32'h80FF1234, 32'h0, 32'h0, 5'd6);
    tick();
    chk("lh_misalign", 64'(bus.LoadMisalignW_o), 64'd1);
    chk("lh_regwrite", 64'(bus.RegWriteW_o), 64'd0);
    chk("lh_cnt", 64'(bus.InstRetW_o), 64'd3);

    // ADDI to x0
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("addi_x0_regwrite", 64'(bus.RegWriteW_o), 64'd0);
    chk("addi_x0_result", 64'(bus.ResultW_o), 64'h55);
    chk("addi_x0_misalign", 64'(bus.LoadMisalignW_o), 64'd0);
    chk("addi_x0_cnt", 64'(bus.InstRetW_o), 64'd3);

    // JAL -> PC+4
    drive(1'b1, 1'b1, 2'b10, 3'b000, 32'h200, 32'h0, 32'h104, 32'h0, 5'd1);
    tick();
    chk("jal_result", 64'(bus.ResultW_o), 64'h104);
    chk("jal_regwrite", 64'(bus.RegWriteW_o), 64'd1);
    chk("jal_cnt", 64'(bus.InstRetW_o), 64'd4);

    // Stall 3 cycles with JAL in W while M presents a new instruction
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h999, 32'h0, 32'h0, 32'h0, 5'd7);
    bus.StallW_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_result", 64'(bus.ResultW_o), 64'h104);
      chk("stall_rd", 64'(bus.RdW_o), 64'd1);
      chk("stall_cnt", 64'(bus.InstRetW_o), 64'd4);
    end
    bus.StallW_i = 1'b0;
    tick();
    chk("release_result", 64'(bus.ResultW_o), 64'h999);
    chk("release_rd", 64'(bus.RdW_o), 64'd7);
    chk("release_cnt", 64'(bus.InstRetW_o), 64'd5);

    // LUI immediate, then flush together with stall: bubble wins, stall blocks count
    drive(1'b1, 1'b1, 2'b11, 3'b000, 32'h0, 32'h0, 32'h0, 32'hABCDE000, 5'd9);
    tick();
    chk("lui_result", 64'(bus.ResultW_o), 64'hABCDE000);
    chk("lui_cnt", 64'(bus.InstRetW_o), 64'd6);
    bus.FlushW_i = 1'b1;
    bus.StallW_i = 1'b1;
    tick();
    chk_idle("flush_stall");
    chk("flush_stall_cnt", 64'(bus.InstRetW_o), 64'd6);
    bus.FlushW_i = 1'b0;
    bus.StallW_i = 1'b0;

    // Flush alone still retires the occupant
    tick();
    chk("refill_valid", 64'(bus.ValidW_o), 64'd1);
    chk("refill_cnt", 64'(bus.InstRetW_o), 64'd6);
    bus.FlushW_i = 1'b1;
    tick();
    chk("flush_valid", 64'(bus.ValidW_o), 64'd0);
    chk("flush_cnt", 64'(bus.InstRetW_o), 64'd7);
    bus.FlushW_i = 1'b0;

    // Counter wrap: W holds a bubble, so 9 valid ticks retire 8 -> 15
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 32'h0, 5'd3);
    for (int i = 0; i < 9; i++) tick();
    chk("pre_wrap_cnt", 64'(bus.InstRetW_o), 64'd15);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("wrap_cnt", 64'(bus.InstRetW_o), 64'd0);
    chk("wrap_valid", 64'(bus.ValidW_o), 64'd0);

    // Reset during stall clears W and counter
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0, 5'd4);
    tick();
    tick();
    chk("pre_rst_cnt", 64'(bus.InstRetW_o), 64'd1);
    bus.StallW_i = 1'b1;
    rst = 1'b1;
    tick();
    chk_idle("rst_stall");
    chk("rst_stall_cnt", 64'(bus.InstRetW_o), 64'd0);
    rst = 1'b0;
    bus.StallW_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mw_writeback.md
Name: mw_writeback

Overview:
- M→W pipeline register plus writeback stage of the pipelined RV32I core.
- Captures the memory-stage outputs: ALU result, the raw 32-bit word from data memory, PC+4, immediate, and control.
- Produces the register-file write port (RegWriteW/RdW/ResultW), which the hazard unit also uses for forwarding.
- Performs load byte/half extraction with sign/zero extension, flags misaligned loads, and keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- StallW_i  input  1  hold the W register contents.
- FlushW_i  input  1  load a bubble into W.
- ValidM_i  input  1  M stage holds a real instruction.
- RegWriteM_i  input  1  instruction writes rd.
- ResultSrcM_i  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- LoadTypeM_i  input  3  load funct3.
- ALUResultM_i  input  32  ALU result; the effective address for loads.
- ReadDataM_i  input  32  word read from data memory; word-aligned, little-endian.
- PCPlus4M_i  input  32  PC+4.
- ImmExtM_i  input  32  extended immediate.
- RdM_i  input  5  destination register.
- ValidW_o  output  1  W holds a real instruction.
- RegWriteW_o  output  1  register-file write enable (qualified).
- RdW_o  output  5  destination register.
- ResultW_o  output  32  writeback data.
- LoadMisalignW_o  output  1  misaligned-load exception flag.
- InstRetW_o  output  CNT_W  retired-instruction count.

Behaviour:
- **Update priority** at each rising edge: rst > FlushW_i > StallW_i > normal load.
  - rst: all W registers and the counter go to 0, so every output reads 0 after reset.
  - Flush: all W registers are cleared to 0, including valid and regwrite.
  - Stall: all W registers hold their values.
  - Normal: W registers capture the M inputs.
- **Latency**: 1 cycle M→W; all outputs are combinational from the W registers.
- **Load extraction**:
  - off = ALUResult_q[1:0].
  - 000 LB: byte off, i.e. word[8*off+7:8*off], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half selected by off[1], sign-extended; misaligned if off[0]=1.
  - 101 LHU: same half, zero-extended; misaligned if off[0]=1.
  - 010 LW: raw word; misaligned if off≠0.
  - 011/110/111: raw word, never misaligned.
- **LoadMisalignW_o** = Valid_q & (ResultSrc_q==01) & misaligned.
- **ResultW_o** mux: 00 ALUResult_q, 01 extracted load, 10 PCPlus4_q, 11 ImmExt_q.
  - ResultW_o is driven even when the slot is invalid.
- **RegWriteW_o** = Valid_q & RegWrite_q & (Rd_q≠0) & ~LoadMisalignW_o. Writes to x0 are never asserted.
- **RdW_o** = Rd_q; **ValidW_o** = Valid_q.
- **Retire counter**:
  - Increments at an edge when Valid_q & ~StallW_i & ~LoadMisalignW_o & ~rst.
  - Each instruction is counted exactly once, on the edge it leaves W.
  - Flush does not block counting of the instruction currently in W.
  - Wraps from all-ones to 0.
- **Simultaneous FlushW_i & StallW_i**: flush wins.
- **rst mid-stall**: registers and counter clear anyway.

Test Plan:
- Reset, then idle 3 cycles with ValidM_i=0 → all outputs 0; InstRetW_o=0.
- LB at ALUResult=0x1003, ReadData=0x80FF1234 → ResultW=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x1002 → 0x000080FF. RegWriteW=1 with Rd=5.
- LW at 0x1002 → LoadMisalignW=1, RegWriteW=0, counter unchanged. LH at 0x1001 → LoadMisalignW=1.
- ADDI to Rd=0 with ALU=0x55 → RegWriteW=0 and ResultW=0x55. JAL with PCPlus4=0x104, ResultSrc=10 → ResultW=0x104.
- Stall W 3 cycles with a valid instruction in W, then release → outputs held, counter increments by 1 only. FlushW with StallW both high → bubble loaded (ValidW=0 next cycle).
- Preload the counter to all-ones (force or parameter CNT_W=4 with 15 retirements), retire one more → counter=0.
